mem_trace_fifo: RTL and testbench

Downstream observer of the single-cycle MIPS top. It captures every committed data-memory store (pc, aluout, writedata) into a circular FIFO. The captured transactions drain through a valid/ready port to a checker or scoreboard. It gives verification an ordered, lossless-or-counted record of memory traffic, so checks do not depend on sampling pc at exact clock edges.

---
 rtl/mem_trace_fifo_if.sv | 35 +++
 rtl/mem_trace_fifo.sv | 127 ++++++++++++
 tb/tb_mem_trace_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_trace_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_trace_fifo_if
// Description : Trace drain port bundle for mem_trace_fifo (valid/ready + entry)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_trace_fifo_if #(
    parameter int DW = 32
);
    logic          trc_valid;
    logic          trc_ready;
    logic          trc_kind;
    logic [DW-1:0] trc_pc;
    logic [DW-1:0] trc_addr;
    logic [DW-1:0] trc_data;

    modport master (
        output trc_valid,
        output trc_kind,
        output trc_pc,
        output trc_addr,
        output trc_data,
        input  trc_ready
    );

    modport slave (
        input  trc_valid,
        input  trc_kind,
        input  trc_pc,
        input  trc_addr,
        input  trc_data,
        output trc_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_trace_fifo
// Description : Circular FIFO recording committed data-memory stores (and,
//               with macro TRACE_LOADS_EN defined, loads) for trace draining.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic [DW-1:0] pc,
    input  wire logic [DW-1:0] aluout,
    input  wire logic [DW-1:0] writedata,
    input  wire logic [DW-1:0] readdata,
    input  wire logic          memwrite,
    input  wire logic          memread,
    mem_trace_fifo_if.master   trc,
    output logic [AW:0]        count,
    output logic               full,
    output logic               empty,
    output logic [15:0]        overflow_cnt
);

    localparam logic [AW:0] C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [15:0] C_OVF_MAX = 16'hFFFF;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_ovf;

    logic [DW-1:0] r_mem_pc   [DEPTH];
    logic [DW-1:0] r_mem_addr [DEPTH];
    logic [DW-1:0] r_mem_data [DEPTH];

    logic          w_push_req;
    logic          w_push_kind;
    logic [DW-1:0] w_push_data;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;

`ifdef TRACE_LOADS_EN
    logic          r_mem_kind [DEPTH];

    // A cycle that both stores and loads records only the store.
    assign w_push_req  = memwrite | memread;
    assign w_push_kind = ~memwrite & memread;
    assign w_push_data = memwrite ? writedata : readdata;
`else
    logic          w_unused_load;

    assign w_push_req    = memwrite;
    assign w_push_kind   = 1'b0;
    assign w_push_data   = writedata;
    assign w_unused_load = memread ^ (^readdata) ^ w_push_kind;
`endif

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_pop     = trc.trc_valid & trc.trc_ready;
    // A pop in the same edge frees the slot a full FIFO would otherwise lack.
    assign w_push_ok = w_push_req & (~w_full | w_pop);
    assign w_drop    = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
            if (w_drop && (r_ovf != C_OVF_MAX)) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    // Storage is deliberately left unreset; stale words never escape the
    // output gating below.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_pc[r_wr_ptr]   <= pc;
            r_mem_addr[r_wr_ptr] <= aluout;
            r_mem_data[r_wr_ptr] <= w_push_data;
`ifdef TRACE_LOADS_EN
            r_mem_kind[r_wr_ptr] <= w_push_kind;
`endif
        end
    end

    always_comb begin
        trc.trc_valid = ~w_empty;
        trc.trc_kind  = 1'b0;
        trc.trc_pc    = '0;
        trc.trc_addr  = '0;
        trc.trc_data  = '0;
        if (!w_empty) begin
`ifdef TRACE_LOADS_EN
            trc.trc_kind = r_mem_kind[r_rd_ptr];
`endif
            trc.trc_pc   = r_mem_pc[r_rd_ptr];
            trc.trc_addr = r_mem_addr[r_rd_ptr];
            trc.trc_data = r_mem_data[r_rd_ptr];
        end
    end

    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign overflow_cnt = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mem_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_trace_fifo
// Description : Randomized + directed scoreboard bench for mem_trace_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_trace_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;
`ifdef TRACE_LOADS_EN
    localparam bit LOADS = 1'b1;
`else
    localparam bit LOADS = 1'b0;
`endif

    typedef struct packed {
        logic          kind;
        logic [DW-1:0] pc;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] pc = '0, aluout = '0, writedata = '0, readdata = '0;
    logic          memwrite = 1'b0, memread = 1'b0;
    logic [AW:0]   count;
    logic          full, empty;
    logic [15:0]   overflow_cnt;

    mem_trace_fifo_if #(.DW(DW)) trc_bus ();

    mem_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .aluout       (aluout),
        .writedata    (writedata),
        .readdata     (readdata),
        .memwrite     (memwrite),
        .memread      (memread),
        .trc          (trc_bus),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    entry_t  exp_q[$];
    int      m_ovf = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue updated from the rules at each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_ovf = 0;
        end else begin
            bit     do_pop;
            bit     req;
            entry_t e;
            do_pop = (exp_q.size() != 0) && trc_bus.trc_ready;
            req    = memwrite || (LOADS && memread);
            e.kind = !memwrite;
            e.pc   = pc;
            e.addr = aluout;
            e.data = memwrite ? writedata : readdata;
            if (do_pop) void'(exp_q.pop_front());
            if (req) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(e);
                else if (m_ovf < 16'hFFFF) m_ovf++;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        chk("valid", trc_bus.trc_valid, exp_q.size() != 0);
        chk("count", count, exp_q.size());
        chk("full", full, exp_q.size() == DEPTH);
        chk("empty", empty, exp_q.size() == 0);
        chk("overflow_cnt", overflow_cnt, m_ovf);
        if (exp_q.size() != 0) begin
            chk("head_kind", trc_bus.trc_kind, exp_q[0].kind);
            chk("head_pc", trc_bus.trc_pc, exp_q[0].pc);
            chk("head_addr", trc_bus.trc_addr, exp_q[0].addr);
            chk("head_data", trc_bus.trc_data, exp_q[0].data);
        end else begin
            chk("idle_kind", trc_bus.trc_kind, 0);
            chk("idle_pc", trc_bus.trc_pc, 0);
            chk("idle_addr", trc_bus.trc_addr, 0);
            chk("idle_data", trc_bus.trc_data, 0);
        end
    end

    task automatic cyc(input logic mw, input logic mr, input logic rdy,
                       input logic [DW-1:0] p, input logic [DW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        memwrite          = mw;
        memread           = mr;
        trc_bus.trc_ready = rdy;
        pc                = p;
        aluout            = a;
        writedata         = wd;
        readdata          = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!empty && n < 40) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            n++;
        end
        chk("drain_timeout", empty, 1);
    endtask

    initial begin
        trc_bus.trc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", trc_bus.trc_valid, 0);
        chk("reset_empty", empty, 1);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Single store, then one-cycle pop
        cyc(1, 0, 0, 32'h0c, 32'd4, 32'd5, 0);
        chk("t2_valid", trc_bus.trc_valid, 1);
        chk("t2_pc", trc_bus.trc_pc, 32'h0c);
        chk("t2_addr", trc_bus.trc_addr, 32'd4);
        chk("t2_data", trc_bus.trc_data, 32'd5);
        chk("t2_count", count, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("t2_empty", empty, 1);

        // Three stores drained in order
        cyc(1, 0, 0, 32'h0c, 32'd4, 32'd5, 0);
        cyc(1, 0, 0, 32'h14, 32'd13, 32'd10, 0);
        cyc(1, 0, 0, 32'h1c, 32'd22, 32'd15, 0);
        chk("t3_count3", count, 3);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("t3_count2", count, 2);
        chk("t3_pc2", trc_bus.trc_pc, 32'h14);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("t3_count1", count, 1);
        chk("t3_pc3", trc_bus.trc_pc, 32'h1c);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("t3_count0", count, 0);

        // Overfill by two
        for (int i = 0; i < 18; i++)
            cyc(1, 0, 0, 32'h100 + 4*i, 32'h200 + i, 32'h300 + i, 0);
        chk("t4_full", full, 1);
        chk("t4_count", count, 16);
        chk("t4_ovf", overflow_cnt, 2);
        chk("t4_head", trc_bus.trc_pc, 32'h100);

        // Push and pop together while full
        cyc(1, 0, 1, 32'h34, 32'h40, 32'h99, 0);
        chk("t5_count", count, 16);
        chk("t5_ovf", overflow_cnt, 2);
        drain();

        // Asynchronous reset mid-stream
        cyc(1, 0, 0, 32'h50, 32'h3, 32'h7, 0);
        cyc(1, 0, 0, 32'h54, 32'h5, 32'h8, 0);
        cyc(1, 0, 0, 32'h58, 32'h6, 32'h9, 0);
        chk("t1_pre_count", count, 3);
        memwrite = 1'b0;
        reset = 1'b0;
        #1;
        chk("t1_valid", trc_bus.trc_valid, 0);
        chk("t1_count", count, 0);
        chk("t1_ovf", overflow_cnt, 0);
        chk("t1_empty", empty, 1);
        chk("t1_pc", trc_bus.trc_pc, 0);
        chk("t1_data", trc_bus.trc_data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Load capture (or lack of it)
        cyc(0, 1, 0, 32'h10, 32'd4, 32'hdead, 32'd5);
`ifdef TRACE_LOADS_EN
        chk("t6_count", count, 1);
        chk("t6_kind", trc_bus.trc_kind, 1);
        chk("t6_data", trc_bus.trc_data, 5);
        cyc(1, 1, 0, 32'h18, 32'd8, 32'h77, 32'h66);
        chk("t6_both_count", count, 2);
`else
        chk("t6_count", count, 0);
        chk("t6_valid", trc_bus.trc_valid, 0);
`endif
        drain();

        // Random traffic with fill/drain phases
        for (int i = 0; i < 3000; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 300) % 2 == 0) ? 25 : 80;
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < rdy_pct,
                $urandom, $urandom, $urandom, $urandom);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
